// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - SIMPLEZ opcodes, FSM/ALU encodings and instruction field helpers
package simplez_pkg;

    // Opcode values carried in the top three bits of RI
    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Control FSM states
    typedef enum logic [2:0] {
        S_INI = 3'd0,
        S_FET = 3'd1,
        S_DEC = 3'd2,
        S_MEM = 3'd3,
        S_HLT = 3'd4
    } state_t;

    // ALU operation select
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_DECR = 2'd2,
        ALU_ZERO = 2'd3
    } alu_op_t;

    // Opcode field: the three most significant bits of a DATAW-wide word.
    // The word is passed zero-extended to 32 bits so one helper serves any width.
    function automatic logic [2:0] co_of(input logic [31:0] ri, input int unsigned dataw);
        logic [31:0] shifted;
        shifted = ri >> (dataw - 3);
        return shifted[2:0];
    endfunction

    // Address field: the ADDRW least significant bits; bits between CD and CO are ignored.
    function automatic logic [31:0] cd_of(input logic [31:0] ri, input int unsigned addrw);
        logic [31:0] mask;
        mask = (32'd1 << addrw) - 32'd1;
        return ri & mask;
    endfunction

endpackage

// File: rtl/simplez_alu.sv
// rtl/simplez_alu.sv - combinational accumulator ALU: pass, add, decrement, zero, zero flag
module simplez_alu
    import simplez_pkg::*;
#(
    parameter int DATAW = 12
) (
    input  alu_op_t          i_op,
    input  logic [DATAW-1:0] i_ac,
    input  logic [DATAW-1:0] i_operand,
    output logic [DATAW-1:0] o_result,
    output logic             o_zero
);

    // Result selection; add and decrement wrap modulo 2^DATAW
    always_comb begin
        o_result = i_operand;
        case (i_op)
            ALU_PASS: o_result = i_operand;
            ALU_ADD:  o_result = i_ac + i_operand;
            ALU_DECR: o_result = i_ac - DATAW'(1);
            ALU_ZERO: o_result = '0;
            default:  o_result = i_operand;
        endcase
    end

    // Zero flag of the current accumulator, used by BZ
    always_comb begin
        o_zero = (i_ac == '0);
    end

endmodule

// File: rtl/simplez_core.sv
// rtl/simplez_core.sv - SIMPLEZ CPU core with handshaked memory port and mapped output register
module simplez_core
    import simplez_pkg::*;
#(
    parameter int               DATAW   = 12,
    parameter int               ADDRW   = 9,
    parameter int               OUTW    = 4,
    parameter logic [ADDRW-1:0] OUTADDR = 'o100
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [OUTW-1:0]  out_port,
    output logic             stop,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [ADDRW-1:0] r_cp;
    logic [DATAW-1:0] r_ri;
    logic [DATAW-1:0] r_ac;
    logic [OUTW-1:0]  r_out;

    logic [2:0]       w_co;
    logic [ADDRW-1:0] w_cd;
    logic             w_st_out;
    logic             w_mem_done;
    logic             w_ac_we;
    alu_op_t          w_alu_op;
    logic [DATAW-1:0] w_alu_result;
    logic             w_ac_zero;

    assign w_co = co_of(32'(r_ri), DATAW);
    assign w_cd = ADDRW'(cd_of(32'(r_ri), ADDRW));

    // A store to the output address never reaches memory and needs no handshake
    assign w_st_out   = (w_co == OP_ST) && (w_cd == OUTADDR);
    assign w_mem_done = w_st_out || mem_ready;

    simplez_alu #(
        .DATAW(DATAW)
    ) u_alu (
        .i_op     (w_alu_op),
        .i_ac     (r_ac),
        .i_operand(mem_rdata),
        .o_result (w_alu_result),
        .o_zero   (w_ac_zero)
    );

    // State register; reset abandons any in-flight request immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_INI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INI: w_next_state = S_FET;
            S_FET: begin
                if (mem_ready) begin
                    w_next_state = S_DEC;
                end
            end
            S_DEC: begin
                case (w_co)
                    OP_ST, OP_LD, OP_ADD: w_next_state = S_MEM;
                    OP_HALT:              w_next_state = S_HLT;
                    default:              w_next_state = S_FET;
                endcase
            end
            S_MEM: begin
                if (w_mem_done) begin
                    w_next_state = S_FET;
                end
            end
            S_HLT:   w_next_state = S_HLT;
            default: w_next_state = S_INI;
        endcase
    end

    // Memory port and status outputs decoded from the current state and registers
    always_comb begin
        mem_addr  = r_cp;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = r_ac;
        busy      = 1'b1;
        stop      = 1'b0;
        case (r_state)
            S_INI: busy = 1'b0;
            S_FET: mem_rd = 1'b1;
            S_DEC: ;
            S_MEM: begin
                mem_addr = w_cd;
                mem_rd   = (w_co == OP_LD) || (w_co == OP_ADD);
                mem_wr   = (w_co == OP_ST) && !w_st_out;
            end
            S_HLT: begin
                busy = 1'b0;
                stop = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // ALU operation and accumulator write enable for the instruction in RI
    always_comb begin
        w_alu_op = ALU_PASS;
        w_ac_we  = 1'b0;
        if (r_state == S_DEC) begin
            if (w_co == OP_CLR) begin
                w_alu_op = ALU_ZERO;
                w_ac_we  = 1'b1;
            end else if (w_co == OP_DEC) begin
                w_alu_op = ALU_DECR;
                w_ac_we  = 1'b1;
            end
        end else if (r_state == S_MEM && mem_ready) begin
            if (w_co == OP_LD) begin
                w_alu_op = ALU_PASS;
                w_ac_we  = 1'b1;
            end else if (w_co == OP_ADD) begin
                w_alu_op = ALU_ADD;
                w_ac_we  = 1'b1;
            end
        end
    end

    // Program counter and instruction register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cp <= '0;
            r_ri <= '0;
        end else begin
            if (r_state == S_FET && mem_ready) begin
                r_ri <= mem_rdata;
                r_cp <= r_cp + ADDRW'(1);
            end else if (r_state == S_DEC) begin
                if (w_co == OP_BR || (w_co == OP_BZ && w_ac_zero)) begin
                    r_cp <= w_cd;
                end
            end
        end
    end

    // Accumulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ac <= '0;
        end else if (w_ac_we) begin
            r_ac <= w_alu_result;
        end
    end

    // Memory-mapped output register, write-only from the program's point of view
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else if (r_state == S_MEM && w_st_out) begin
            r_out <= r_ac[OUTW-1:0];
        end
    end

    assign out_port = r_out;

endmodule

// File: tb/tb_simplez_core.sv
// tb/tb_simplez_core.sv - self-checking bench for simplez_core against an instruction-level model
module tb_simplez_core;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [3:0]  out_port;
    logic        stop;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [512];
    int          img [512];
    int          mm  [512];

    int          w_cur = 0;
    int          wcnt = 0;
    bit          pend = 0;
    logic [8:0]  s_addr;
    logic [11:0] s_wdata;
    logic        s_rd, s_wr;
    int          wr_cycles = 0;
    int          last_cyc = 0;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } acc_t;
    acc_t exp_q[$];
    acc_t obs_q[$];

    simplez_core dut (
        .clk      (clk),
        .rstn     (rstn),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .out_port (out_port),
        .stop     (stop),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory with w_cur wait cycles per request; decides ready mid-cycle
    always @(negedge clk) begin
        if (!rstn) begin
            mem_ready <= 1'b0;
            wcnt = 0;
            pend = 0;
        end else begin
            checks++;
            assert (!(mem_rd && mem_wr)) else begin
                errors++;
                $error("FAIL rd_wr_exclusive observed rd=%0b wr=%0b expected not both", mem_rd, mem_wr);
            end
            if (mem_wr) wr_cycles++;
            if (mem_rd || mem_wr) begin
                if (pend) begin
                    checks++;
                    assert ({mem_addr, mem_wdata, mem_rd, mem_wr} === {s_addr, s_wdata, s_rd, s_wr}) else begin
                        errors++;
                        $error("FAIL req_stable observed addr=%0h wd=%0h rd=%0b wr=%0b expected addr=%0h wd=%0h rd=%0b wr=%0b",
                               mem_addr, mem_wdata, mem_rd, mem_wr, s_addr, s_wdata, s_rd, s_wr);
                    end
                end
                if (wcnt >= w_cur) begin
                    mem_ready <= 1'b1;
                    wcnt = 0;
                    pend = 0;
                    obs_q.push_back('{mem_wr, int'(mem_addr), mem_wr ? int'(mem_wdata) : int'(mem_rdata)});
                    if (mem_wr) mem[mem_addr] <= mem_wdata;
                end else begin
                    mem_ready <= 1'b0;
                    wcnt++;
                    pend = 1;
                    s_addr = mem_addr;
                    s_wdata = mem_wdata;
                    s_rd = mem_rd;
                    s_wr = mem_wr;
                end
            end else begin
                mem_ready <= 1'b0;
                wcnt = 0;
                pend = 0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Instruction-level model: executes the program, lists every memory access, counts cycles
    task automatic model_run(input int w, output int cyc, output int outp);
        int pc, ac, ins, co, cd, steps;
        bit done;
        for (int i = 0; i < 512; i++) mm[i] = img[i];
        pc = 0; ac = 0; outp = 0; cyc = 0; steps = 0; done = 0;
        exp_q.delete();
        while (!done && steps < 10000) begin
            steps++;
            ins = mm[pc];
            exp_q.push_back('{1'b0, pc, ins});
            cyc += 2 + w;
            pc = (pc + 1) % 512;
            co = ins / 512;
            cd = ins % 512;
            case (co)
                0: if (cd == 64) begin
                       outp = ac % 16;
                       cyc += 1;
                   end else begin
                       mm[cd] = ac;
                       exp_q.push_back('{1'b1, cd, ac});
                       cyc += 1 + w;
                   end
                1: begin exp_q.push_back('{1'b0, cd, mm[cd]}); ac = mm[cd]; cyc += 1 + w; end
                2: begin exp_q.push_back('{1'b0, cd, mm[cd]}); ac = (ac + mm[cd]) % 4096; cyc += 1 + w; end
                3: pc = cd;
                4: if (ac == 0) pc = cd;
                5: ac = 0;
                6: ac = (ac + 4095) % 4096;
                default: done = 1;
            endcase
        end
    endtask

    task automatic run_prog(input string name, input int w);
        int ecyc, eout, cyc, nbad, n;
        w_cur = w;
        for (int i = 0; i < 512; i++) mem[i] = 12'(img[i]);
        model_run(w, ecyc, eout);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, ":reset_outputs"},
            int'({mem_addr, mem_rd, mem_wr, mem_wdata, out_port, stop, busy}), 0);
        obs_q.delete();
        wr_cycles = 0;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk({name, ":first_fetch"}, int'({mem_rd, mem_wr, mem_addr}), 1024);
        chk({name, ":busy_run"}, int'(busy), 1);
        cyc = 0;
        while (!stop && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        last_cyc = cyc;
        chk({name, ":stop"}, int'(stop), 1);
        chk({name, ":busy_halt"}, int'(busy), 0);
        chk({name, ":cycles"}, cyc, ecyc);
        chk({name, ":out_port"}, int'(out_port), eout);
        chk({name, ":n_access"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, ":acc_kind_addr"}, obs_q[i].addr + (obs_q[i].wr ? 1024 : 0),
                exp_q[i].addr + (exp_q[i].wr ? 1024 : 0));
            chk({name, ":acc_data"}, obs_q[i].data, exp_q[i].data);
        end
        nbad = 0;
        for (int i = 0; i < 512; i++) if (int'(mem[i]) != mm[i]) nbad++;
        chk({name, ":mem_image"}, nbad, 0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 512; i++) img[i] = 0;
    endtask

    initial begin
        int t, r, tgt;
        int bzseq[7];

        // LD/ADD/ST with wrap-around sum, zero and three wait states
        clear_img();
        img[0] = 'o1010; img[1] = 'o2011; img[2] = 'o0012; img[3] = 'o7000;
        img[8] = 'o7777; img[9] = 2;
        run_prog("ldaddst_w0", 0);
        chk("ldaddst_w0:m10", int'(mem[10]), 1);
        chk("ldaddst_w0:cyc11", last_cyc, 11);
        run_prog("ldaddst_w3", 3);
        chk("ldaddst_w3:m10", int'(mem[10]), 1);
        chk("ldaddst_w3:cyc32", last_cyc, 32);

        // Output port store and unconditional branch
        clear_img();
        img[0] = 'o5000; img[1] = 'o6000; img[2] = 'o0100; img[3] = 'o3004; img[4] = 'o7000;
        run_prog("outport", 0);
        chk("outport:value", int'(out_port), 15);
        chk("outport:no_wr", wr_cycles, 0);
        run_prog("outport_w2", 2);
        chk("outport_w2:no_wr", wr_cycles, 0);

        // BZ taken with AC=0, not taken with AC=5, CP wrap from the last location
        clear_img();
        img[0] = 'o4010; img[1] = 'o7000;
        img[8] = 'o1200; img[9] = 'o3777; img[511] = 'o4300;
        img[128] = 5;
        bzseq = '{0, 8, 128, 9, 511, 0, 1};
        run_prog("bz_w0", 0);
        chk("bz_w0:n_fetch", obs_q.size(), 7);
        for (int i = 0; i < 7 && i < obs_q.size(); i++) chk("bz_w0:seq_addr", obs_q[i].addr, bzseq[i]);
        run_prog("bz_w2", 2);

        // Random forward-only programs over a small data window
        for (int k = 0; k < 6; k++) begin
            clear_img();
            for (int d = 128; d < 136; d++) img[d] = int'($urandom_range(0, 4095));
            for (int i = 0; i < 15; i++) begin
                r = int'($urandom_range(0, 7));
                tgt = i + 1 + int'($urandom_range(0, 14 - i));
                case (r)
                    0: img[i] = 'o1000 + 128 + int'($urandom_range(0, 7));
                    1: img[i] = 'o2000 + 128 + int'($urandom_range(0, 7));
                    2: img[i] = 'o0000 + 128 + int'($urandom_range(0, 7));
                    3: img[i] = 'o0100;
                    4: img[i] = 'o5000;
                    5: img[i] = 'o6000;
                    6: img[i] = 'o3000 + tgt;
                    default: img[i] = 'o4000 + tgt;
                endcase
            end
            img[15] = 'o7000;
            run_prog("random", int'($urandom_range(0, 3)));
        end

        // Reset asserted in the middle of a held write
        clear_img();
        img[0] = 'o0012; img[1] = 'o7000; img[10] = 'o1234;
        for (int i = 0; i < 512; i++) mem[i] = 12'(img[i]);
        w_cur = 5;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        t = 0;
        while (!mem_wr && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_st:wr_seen", int'(mem_wr), 1);
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("rst_st:wr_dropped", int'(mem_wr), 0);
        chk("rst_st:outputs", int'({mem_addr, mem_rd, mem_wr, mem_wdata, out_port, stop, busy}), 0);
        chk("rst_st:m10_kept", int'(mem[10]), 'o1234);
        w_cur = 0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_st:ini_no_req", int'({mem_rd, mem_wr}), 0);
        @(posedge clk); #1;
        chk("rst_st:refetch0", int'({mem_rd, mem_wr, mem_addr}), 1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
